// File: rtl/alu_types_pkg.sv
// Shared types for the multicycle ALU: opcode encoding and FSM state enum.
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_MUL  = 4'b1001,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1110
    } alu_control_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } alu_state_t;

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-style adder with carry in/out, shared by ADD/SUB/SLT/SLTU.
module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/alu_shift_unit.sv
// Bit-serial shifter: load performs the first shift, each step one more bit.
module alu_shift_unit #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 left,
    input  logic                 arith,
    input  logic [N-1:0]         data_in,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         data,
    output logic                 done
);

    localparam int SW = $clog2(N);

    logic [N-1:0]  data_reg;
    logic [SW-1:0] count_reg;
    logic          left_reg;
    logic          fill_reg;
    logic          fill_in;

    function automatic logic [N-1:0] shift1(input logic [N-1:0] v, input logic l, input logic f);
        return l ? {v[N-2:0], 1'b0} : {f, v[N-1:1]};
    endfunction

    // Arithmetic fill is taken from the operand at load and held for all steps.
    assign fill_in = arith & data_in[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            count_reg <= '0;
            left_reg  <= 1'b0;
            fill_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= shift1(data_in, left, fill_in);
            count_reg <= shamt - SW'(1);
            left_reg  <= left;
            fill_reg  <= fill_in;
        end else if (step && count_reg != '0) begin
            data_reg  <= shift1(data_reg, left_reg, fill_reg);
            count_reg <= count_reg - SW'(1);
        end
    end

    assign data = data_reg;
    assign done = (count_reg == '0);

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes; serial shifts, optional serial
// multiply enabled by defining ALU_MULTICYCLE_MUL_EN.
module alu_multicycle
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal,
    output logic         busy
);

    localparam int SW = $clog2(N);

    alu_state_t    state_reg, state_next;
    logic [N-1:0]  result_reg, res_next;
    logic          overflow_reg, ovf_next;
    logic          zero_reg, equal_reg;
    logic          res_load, accept;

    logic          sub_like, is_shift;
    logic [N-1:0]  add_b, sum;
    logic          cout, add_ovf, sub_ovf, slt_bit;
    logic [N-1:0]  fast_result;
    logic          fast_ovf;

    logic          shift_load, shift_step, shift_done;
    logic [N-1:0]  shift_data;
    logic [SW-1:0] shamt;

    assign shamt    = b[SW-1:0];
    assign sub_like = (control == ALU_SUB) || (control == ALU_SLT) || (control == ALU_SLTU);
    assign is_shift = (control == ALU_SLL) || (control == ALU_SRL) || (control == ALU_SRA);
    assign add_b    = sub_like ? ~b : b;

    adder_n #(.N(N)) u_adder (
        .a   (a),
        .b   (add_b),
        .cin (sub_like),
        .sum (sum),
        .cout(cout)
    );

    assign add_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    assign sub_ovf = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
    // Signed less-than is the difference sign corrected for overflow.
    assign slt_bit = sum[N-1] ^ sub_ovf;

    always_comb begin
        fast_result = '0;
        fast_ovf    = 1'b0;
        case (control)
            ALU_AND:  fast_result = a & b;
            ALU_OR:   fast_result = a | b;
            ALU_XOR:  fast_result = a ^ b;
            ALU_SLL, ALU_SRL, ALU_SRA: fast_result = a;
            ALU_ADD:  begin fast_result = sum; fast_ovf = add_ovf; end
            ALU_SUB:  begin fast_result = sum; fast_ovf = sub_ovf; end
            ALU_SLT:  fast_result = {{(N-1){1'b0}}, slt_bit};
            ALU_SLTU: fast_result = {{(N-1){1'b0}}, ~cout};
            default:  fast_result = '0;
        endcase
    end

    alu_shift_unit #(.N(N)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (shift_load),
        .step   (shift_step),
        .left   (control == ALU_SLL),
        .arith  (control == ALU_SRA),
        .data_in(a),
        .shamt  (shamt),
        .data   (shift_data),
        .done   (shift_done)
    );

`ifdef ALU_MULTICYCLE_MUL_EN
    localparam int CW = $clog2(N) + 1;

    logic [2*N-1:0] mul_acc_reg, mul_mcand_reg, mul_acc_next;
    logic [N-1:0]   mul_mplier_reg;
    logic [CW-1:0]  mul_cnt_reg;
    logic           mul_start, mul_step;

    assign mul_acc_next = mul_mplier_reg[0] ? (mul_acc_reg + mul_mcand_reg) : mul_acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= '0;
            mul_mplier_reg <= '0;
            mul_cnt_reg    <= '0;
        end else if (mul_start) begin
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= {{N{1'b0}}, a};
            mul_mplier_reg <= b;
            mul_cnt_reg    <= CW'(N);
        end else if (mul_step) begin
            mul_acc_reg    <= mul_acc_next;
            mul_mcand_reg  <= mul_mcand_reg << 1;
            mul_mplier_reg <= mul_mplier_reg >> 1;
            mul_cnt_reg    <= mul_cnt_reg - CW'(1);
        end
    end
`endif

    assign accept = in_valid && (state_reg == ST_IDLE);

    always_comb begin
        state_next = state_reg;
        shift_load = 1'b0;
        shift_step = 1'b0;
        res_load   = 1'b0;
        res_next   = '0;
        ovf_next   = 1'b0;
`ifdef ALU_MULTICYCLE_MUL_EN
        mul_start  = 1'b0;
        mul_step   = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift && shamt != '0) begin
                        shift_load = 1'b1;
                        state_next = ST_SHIFT;
                    end
`ifdef ALU_MULTICYCLE_MUL_EN
                    else if (control == ALU_MUL) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end
`endif
                    else begin
                        res_load   = 1'b1;
                        res_next   = fast_result;
                        ovf_next   = fast_ovf;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    res_load   = 1'b1;
                    res_next   = shift_data;
                    state_next = ST_DONE;
                end else begin
                    shift_step = 1'b1;
                end
            end
`ifdef ALU_MULTICYCLE_MUL_EN
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_cnt_reg == CW'(1)) begin
                    res_load   = 1'b1;
                    res_next   = mul_acc_next[N-1:0];
                    ovf_next   = |mul_acc_next[2*N-1:N];
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
            equal_reg    <= 1'b0;
        end else begin
            if (accept) begin
                equal_reg <= (a == b);
            end
            if (res_load) begin
                result_reg   <= res_next;
                overflow_reg <= ovf_next;
                zero_reg     <= (res_next == '0);
            end
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign result    = result_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;
    assign equal     = equal_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle; MUL expectations follow ALU_MULTICYCLE_MUL_EN.
module tb_alu_multicycle;
    import alu_types::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    alu_control_t control = ALU_AND;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] result;
    logic         overflow, zero, equal, busy;

    alu_multicycle #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .control  (control),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow),
        .zero     (zero),
        .equal    (equal),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [N-1:0] res;
        logic         ovf;
        logic         zr;
        logic         eq;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Monitor: compare the head of the scoreboard every cycle the result is held.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                fail("unexpected_out_valid");
            end else begin
                exp_t e;
                e = q[0];
                if (!seen) begin
                    seen = 1'b1;
                    chk({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
                end
                chk({e.name, "_result"}, 64'(result), 64'(e.res));
                chk({e.name, "_overflow"}, 64'(overflow), 64'(e.ovf));
                chk({e.name, "_zero"}, 64'(zero), 64'(e.zr));
                chk({e.name, "_equal"}, 64'(equal), 64'(e.eq));
                if (out_ready) begin
                    $display("txn %s: result=0x%08h ovf=%0b zero=%0b equal=%0b", e.name, result, overflow, zero, equal);
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input string name, input alu_control_t op, input logic [N-1:0] av,
                         input logic [N-1:0] bv, input logic [N-1:0] er, input logic eo,
                         input logic ez, input logic ee, input int lat);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail({name, "_accept_timeout"});
            return;
        end
        control  = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back('{name, er, eo, ez, ee, lat, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            fail("drain_timeout");
            q.delete();
            seen = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({overflow, zero, equal}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1);
        drain();

        issue("sra_31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32);
        for (int n = 0; n < 40 && !out_valid; n++) begin
            chk("sra_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        drain();

        out_ready = 1'b0;
        issue("sub_hold", ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_in_ready_low", 64'(in_ready), 64'd0);
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_in_ready_back", 64'(in_ready), 64'd1);
        chk("hold_out_valid_drop", 64'(out_valid), 64'd0);
        drain();

        issue("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1);
        drain();
        issue("slt", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1);
        drain();
        issue("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1);
        drain();
        issue("xor_eq", ALU_XOR, 32'hFFFF_0000, 32'hFFFF_0000, 32'd0, 1'b0, 1'b1, 1'b1, 1);
        drain();
        issue("illegal", alu_control_t'(4'b0000), 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1);
        drain();
        issue("srl_4", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 5);
        drain();
        issue("sra_1", ALU_SRA, 32'h4000_0000, 32'd1, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 2);
        drain();
        issue("sll_0", ALU_SLL, 32'h1234_5678, 32'd32, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1);
        drain();
        issue("sub_ovf", ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1);
        drain();
        issue("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1);
        drain();

        issue("sll_reset", ALU_SLL, 32'd1, 32'd20, 32'h0010_0000, 1'b0, 1'b0, 1'b0, 21);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_sll_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        q.delete();
        seen = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'({overflow, zero, equal}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue("add_after_reset", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1);
        drain();

`ifdef ALU_MULTICYCLE_MUL_EN
        issue("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b1, 1'b1, 33);
`else
        issue("mul_illegal", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b1, 1);
`endif
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter N, default 32: operand/result width; legal values are powers of two, 8..64.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a, b  input  N  operands.
REQ-007 SHALL have port control  input  alu_control_t (4)  opcode.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  N  operation result.
REQ-011 SHALL have ports overflow, zero, equal  output  1 each  flags for the held result.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL use opcodes AND=0001, OR=0010, XOR=0011, SLL=0101, SRL=0110, SRA=0111, ADD=1000, SUB=1100, SLT=1101, SLTU=1110; all other codes are illegal.
REQ-014 SHALL implement FSM states IDLE, SHIFT, MUL, DONE.
REQ-015 SHALL assert in_ready only in IDLE; a request is accepted when in_valid&in_ready, and a, b and control are captured at that edge.
REQ-016 SHALL, for logic, add/sub, SLT/SLTU and illegal ops, go IDLE->DONE with out_valid high on the cycle after acceptance (latency 1).
REQ-017 SHALL, for shifts, use shamt=b[log2(N)-1:0], shift one bit per cycle in SHIFT, and assert out_valid exactly 1+shamt cycles after acceptance; shamt=0 behaves as latency 1.
REQ-018 SHALL fill SRA with the captured a[N-1], and SLL/SRL with 0.
REQ-019 SHALL set overflow for ADD when the operand signs are equal and the result sign differs; for SUB when the operand signs differ and the result sign differs from a; 0 for all other ops.
REQ-020 SHALL produce SLT/SLTU results of 1 or 0 in bit 0, zero-extended.
REQ-021 SHALL produce result=0 and overflow=0 for illegal opcodes.
REQ-022 SHALL set zero=(result==0) and equal=(a==b) from the captured operands.
REQ-023 SHALL hold result and flags stable in DONE until out_valid&out_ready, then go DONE->IDLE; in_ready is not raised in that same cycle.
REQ-024 SHALL wrap ADD/SUB modulo 2^N.

Reset
REQ-025 SHALL, on rst_n low, immediately set state=IDLE, in_ready=1 (after release), out_valid=0, busy=0, and result, overflow, zero, equal, counters and operand registers to 0.
REQ-026 SHALL abandon an in-flight operation on reset mid-operation, with no out_valid produced for it.

Configuration
REQ-027 SHALL, with ALU_MULTICYCLE_MUL_EN defined, support MUL=1001: iterative shift-add in the MUL state giving the low N bits of the unsigned product, latency N+1, overflow=1 iff the high N product bits are nonzero.
REQ-028 SHALL, without ALU_MULTICYCLE_MUL_EN, treat 1001 as illegal per REQ-021, and the MUL state and datapath SHALL be absent.

Structure
REQ-029 SHALL keep alu_control_t with its opcode values (including MUL) and the FSM state enum in the shared package alu_types.
REQ-030 SHALL instantiate the existing adder_n for ADD/SUB/SLT/SLTU; SUB uses a + ~b with carry-in 1.
REQ-031 SHALL place the bit-serial shifter in one sub-module, alu_shift_unit (load, step, done).

Verification
REQ-032 Bench SHALL check: ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, out_valid one cycle after acceptance.
REQ-033 Bench SHALL check: SRA a=0x80000000, b=31 -> result 0xFFFFFFFF, out_valid 32 cycles after acceptance, in_ready low throughout.
REQ-034 Bench SHALL check: SUB a=5, b=5 with out_ready held low 10 cycles -> result 0, zero=1, equal=1, outputs stable until the handshake, then in_ready returns.
REQ-035 Bench SHALL check: SLTU a=1, b=0xFFFFFFFF -> result 1; SLT with the same operands -> result 0.
REQ-036 Bench SHALL check: rst_n pulsed low mid-SLL with b=20 -> out_valid=0 and all outputs 0 immediately; the next ADD 2+3 -> 5.
REQ-037 Bench SHALL check, with MUL_EN defined: MUL 0x10000 x 0x10000 -> result 0, overflow=1, latency 33; with MUL_EN undefined: same opcode -> result 0, latency 1.
